// File: rtl/async_line_fifo.sv
// Dual-clock FIFO with Gray-coded pointer crossing, plus line counting
// across domains and end-of-line tagging on readout.
module async_line_fifo #(
    parameter int WIDTH     = 8,
    parameter int AWIDTH    = 11,
    parameter int LWIDTH    = 11,
    parameter int LCW       = 4,
    parameter int AF_MARGIN = 4
) (
    input  logic              wr_clk,
    input  logic              wr_rstn,
    input  logic              rd_clk,
    input  logic              rd_rstn,
    input  logic [LWIDTH-1:0] line_len,
    input  logic              wr_en,
    input  logic [WIDTH-1:0]  wr_data,
    output logic              wr_full,
    output logic              wr_almost_full,
    output logic              wr_overflow,
    input  logic              rd_en,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid,
    output logic              rd_eol,
    output logic              rd_empty,
    output logic [LCW:0]      rd_line_avail,
    output logic              rd_underflow
);
    localparam int DEPTH = 1 << AWIDTH;
    localparam logic [AWIDTH:0] AF_TH = (AWIDTH+1)'(DEPTH - AF_MARGIN);
    localparam logic [AWIDTH:0] P_ONE = (AWIDTH+1)'(1);
    localparam logic [LCW:0] L_ONE = (LCW+1)'(1);
    localparam logic [LWIDTH-1:0] C_ONE = LWIDTH'(1);

    function automatic logic [AWIDTH:0] p_g2b(input logic [AWIDTH:0] g);
        logic [AWIDTH:0] b;
        b[AWIDTH] = g[AWIDTH];
        for (int i = AWIDTH - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic logic [LCW:0] l_g2b(input logic [LCW:0] g);
        logic [LCW:0] b;
        b[LCW] = g[LCW];
        for (int i = LCW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic              line_en;

    logic [AWIDTH:0]   wr_ptr_q, wr_ptr_d, wr_gray_q;
    logic [AWIDTH:0]   rg_s1_q, rg_s2_q, wr_occ;
    logic [LWIDTH-1:0] wr_col_q, wr_col_d;
    logic [LCW:0]      wr_lines_q, wr_lines_d, wl_gray_q;
    logic              wr_ovf_q, wr_af_q, wr_acc;

    logic [AWIDTH:0]   rd_ptr_q, rd_ptr_d, rd_gray_q;
    logic [AWIDTH:0]   wg_s1_q, wg_s2_q;
    logic [LWIDTH-1:0] rd_col_q, rd_col_d;
    logic [LCW:0]      rd_lines_q, rd_lines_d;
    logic [LCW:0]      wl_s1_q, wl_s2_q, rd_avail_q, rd_avail_d;
    logic [WIDTH-1:0]  rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_eol_q, rd_eol_d, rd_uf_q, rd_acc;

    assign line_en = line_len != '0;

    // Full: Gray pointers one lap apart differ in the top two bits only.
    assign wr_full = wr_gray_q ==
        {~rg_s2_q[AWIDTH:AWIDTH-1], rg_s2_q[AWIDTH-2:0]};
    assign wr_acc  = wr_en && !wr_full;
    assign wr_occ  = wr_ptr_d - p_g2b(rg_s2_q);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        wr_col_d   = wr_col_q;
        wr_lines_d = wr_lines_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + P_ONE;
            if (line_en) begin
                if (wr_col_q == line_len - C_ONE) begin
                    wr_col_d   = '0;
                    wr_lines_d = wr_lines_q + L_ONE;
                end else begin
                    wr_col_d = wr_col_q + C_ONE;
                end
            end
        end
    end

    always_ff @(posedge wr_clk) begin
        if (wr_acc) mem_q[wr_ptr_q[AWIDTH-1:0]] <= wr_data;
    end

    always_ff @(posedge wr_clk or negedge wr_rstn) begin
        if (!wr_rstn) begin
            wr_ptr_q   <= '0;
            wr_gray_q  <= '0;
            rg_s1_q    <= '0;
            rg_s2_q    <= '0;
            wr_col_q   <= '0;
            wr_lines_q <= '0;
            wl_gray_q  <= '0;
            wr_ovf_q   <= 1'b0;
            wr_af_q    <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            wr_gray_q  <= wr_ptr_d ^ (wr_ptr_d >> 1);
            rg_s1_q    <= rd_gray_q;
            rg_s2_q    <= rg_s1_q;
            wr_col_q   <= wr_col_d;
            wr_lines_q <= wr_lines_d;
            wl_gray_q  <= wr_lines_d ^ (wr_lines_d >> 1);
            wr_ovf_q   <= wr_ovf_q | (wr_en & wr_full);
            wr_af_q    <= wr_occ >= AF_TH;
        end
    end

    assign wr_almost_full = wr_af_q;
    assign wr_overflow    = wr_ovf_q;

    assign rd_empty = rd_gray_q == wg_s2_q;
    assign rd_acc   = rd_en && !rd_empty;

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        rd_col_d   = rd_col_q;
        rd_lines_d = rd_lines_q;
        rd_data_d  = rd_data_q;
        rd_eol_d   = 1'b0;
        if (rd_acc) begin
            rd_ptr_d  = rd_ptr_q + P_ONE;
            rd_data_d = mem_q[rd_ptr_q[AWIDTH-1:0]];
            if (line_en) begin
                if (rd_col_q == line_len - C_ONE) begin
                    rd_col_d   = '0;
                    rd_lines_d = rd_lines_q + L_ONE;
                    rd_eol_d   = 1'b1;
                end else begin
                    rd_col_d = rd_col_q + C_ONE;
                end
            end
        end
        // A line being read stays counted until its last word leaves.
        rd_avail_d = line_en ? l_g2b(wl_s2_q) - rd_lines_d : rd_avail_q;
    end

    always_ff @(posedge rd_clk or negedge rd_rstn) begin
        if (!rd_rstn) begin
            rd_ptr_q   <= '0;
            rd_gray_q  <= '0;
            wg_s1_q    <= '0;
            wg_s2_q    <= '0;
            rd_col_q   <= '0;
            rd_lines_q <= '0;
            wl_s1_q    <= '0;
            wl_s2_q    <= '0;
            rd_avail_q <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_eol_q   <= 1'b0;
            rd_uf_q    <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            rd_gray_q  <= rd_ptr_d ^ (rd_ptr_d >> 1);
            wg_s1_q    <= wr_gray_q;
            wg_s2_q    <= wg_s1_q;
            rd_col_q   <= rd_col_d;
            rd_lines_q <= rd_lines_d;
            wl_s1_q    <= wl_gray_q;
            wl_s2_q    <= wl_s1_q;
            rd_avail_q <= rd_avail_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_acc;
            rd_eol_q   <= rd_eol_d;
            rd_uf_q    <= rd_uf_q | (rd_en & rd_empty);
        end
    end

    assign rd_data       = rd_data_q;
    assign rd_valid      = rd_valid_q;
    assign rd_eol        = rd_eol_q;
    assign rd_line_avail = rd_avail_q;
    assign rd_underflow  = rd_uf_q;

endmodule

// File: tb/tb_async_line_fifo.sv
// Bench for async_line_fifo: queue scoreboard plus line arithmetic
// model, small depth so full, wrap and line framing are reached.
`timescale 1ns/1ps
module tb_async_line_fifo;
    localparam int W  = 8;
    localparam int AW = 4;
    localparam int LW = 11;
    localparam int LC = 4;

    logic          wr_clk = 1'b0;
    logic          rd_clk = 1'b0;
    logic          wr_rstn, rd_rstn;
    logic [LW-1:0] line_len;
    logic          wr_en, rd_en;
    logic [W-1:0]  wr_data, rd_data;
    logic          wr_full, wr_almost_full, wr_overflow;
    logic          rd_valid, rd_eol, rd_empty, rd_underflow;
    logic [LC:0]   rd_line_avail;

    realtime       rd_half = 6.667;
    int            vecs = 0;
    int            errs = 0;
    int            rd_edges = 0;
    int            wr_total = 0;
    int            rd_total = 0;
    int            ll = 0;
    logic [W-1:0]  mq[$];

    always #5 wr_clk = ~wr_clk;
    always #(rd_half) rd_clk = ~rd_clk;
    always @(posedge rd_clk) rd_edges = rd_edges + 1;

    async_line_fifo #(
        .WIDTH(W), .AWIDTH(AW), .LWIDTH(LW), .LCW(LC), .AF_MARGIN(4)
    ) dut (
        .wr_clk(wr_clk), .wr_rstn(wr_rstn),
        .rd_clk(rd_clk), .rd_rstn(rd_rstn),
        .line_len(line_len),
        .wr_en(wr_en), .wr_data(wr_data),
        .wr_full(wr_full), .wr_almost_full(wr_almost_full),
        .wr_overflow(wr_overflow),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_eol(rd_eol), .rd_empty(rd_empty),
        .rd_line_avail(rd_line_avail), .rd_underflow(rd_underflow)
    );

    // Complete lines written minus complete lines read, modulo 2^(LC+1).
    function automatic logic [LC:0] avail_model();
        if (ll == 0) return '0;
        return (LC+1)'(wr_total / ll - rd_total / ll);
    endfunction

    task automatic apply_reset(input int len);
        wr_rstn = 1'b0; rd_rstn = 1'b0;
        wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        ll = len; line_len = LW'(len);
        repeat (5) @(posedge wr_clk);
        #1;
        wr_rstn = 1'b1; rd_rstn = 1'b1;
        mq.delete(); wr_total = 0; rd_total = 0;
        repeat (3) @(posedge wr_clk);
        #1;
    endtask

    task automatic settle();
        repeat (6) @(posedge rd_clk);
        repeat (6) @(posedge wr_clk);
        #1;
    endtask

    task automatic write_word(input logic [W-1:0] d);
        wr_en = 1'b1; wr_data = d;
        @(posedge wr_clk); #1;
        wr_en = 1'b0;
        mq.push_back(d); wr_total++;
    endtask

    task automatic read_burst(input int n, input string tag);
        logic [W-1:0] exp_d;
        logic         exp_e;
        @(posedge rd_clk); #1;
        rd_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge rd_clk); #1;
            vecs++;
            if (rd_valid !== 1'b1 || mq.size() == 0) begin
                errs++;
                $display("FAIL %s_valid[%0d]: got %b want 1 (model %0d)",
                         tag, i, rd_valid, mq.size());
            end else begin
                exp_d = mq.pop_front();
                exp_e = (ll == 0) ? 1'b0 : (((rd_total + 1) % ll) == 0);
                rd_total++;
                vecs++;
                if (rd_data !== exp_d) begin
                    errs++;
                    $display("FAIL %s_data[%0d]: got %h want %h",
                             tag, i, rd_data, exp_d);
                end
                vecs++;
                if (rd_eol !== exp_e) begin
                    errs++;
                    $display("FAIL %s_eol[%0d]: got %b want %b",
                             tag, i, rd_eol, exp_e);
                end
            end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        wr_rstn = 1'b0; rd_rstn = 1'b0;
        wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        ll = 0; line_len = '0;
        repeat (5) @(posedge wr_clk);
        #1;
        vecs++;
        if (rd_empty !== 1'b1) begin
            errs++; $display("FAIL reset_empty: got %b want 1", rd_empty);
        end
        vecs++;
        if (wr_full !== 1'b0) begin
            errs++; $display("FAIL reset_full: got %b want 0", wr_full);
        end
        vecs++;
        if (rd_valid !== 1'b0 || rd_line_avail !== '0) begin
            errs++;
            $display("FAIL reset_rd: got valid %b avail %0d want 0 0",
                     rd_valid, rd_line_avail);
        end
        vecs++;
        if (wr_overflow !== 1'b0 || rd_underflow !== 1'b0) begin
            errs++;
            $display("FAIL reset_sticky: got ovf %b udf %b want 0 0",
                     wr_overflow, rd_underflow);
        end
        wr_rstn = 1'b1; rd_rstn = 1'b1;
        repeat (4) @(posedge wr_clk);
        #1;
        vecs++;
        if (rd_empty !== 1'b1 || wr_full !== 1'b0 ||
            wr_almost_full !== 1'b0) begin
            errs++;
            $display("FAIL post_reset: got empty %b full %b af %b want 1 0 0",
                     rd_empty, wr_full, wr_almost_full);
        end
    endtask

    task automatic test_latency();
        int e0;
        int polls;
        @(posedge wr_clk); #1;
        wr_en = 1'b1; wr_data = 8'hA5;
        @(posedge wr_clk);
        e0 = rd_edges;
        #1;
        wr_en = 1'b0;
        mq.push_back(8'hA5); wr_total++;
        polls = 0;
        while (rd_empty === 1'b1 && polls < 200) begin
            #1; polls++;
        end
        vecs++;
        if (rd_empty !== 1'b0 || rd_edges - e0 > 3) begin
            errs++;
            $display("FAIL latency: got empty %b after %0d rd edges want 0 within 3",
                     rd_empty, rd_edges - e0);
        end
        read_burst(1, "latency");
        @(posedge rd_clk); #1;
        vecs++;
        if (rd_valid !== 1'b0) begin
            errs++; $display("FAIL latency_pulse: got valid %b want 0", rd_valid);
        end
    endtask

    task automatic test_fill();
        logic exp_af;
        logic exp_f;
        settle();
        for (int i = 1; i <= 16; i++) begin
            write_word(W'($urandom));
            exp_af = (i >= 12);
            exp_f  = (i == 16);
            vecs++;
            if (wr_almost_full !== exp_af) begin
                errs++;
                $display("FAIL fill_af[%0d]: got %b want %b",
                         i, wr_almost_full, exp_af);
            end
            vecs++;
            if (wr_full !== exp_f) begin
                errs++;
                $display("FAIL fill_full[%0d]: got %b want %b", i, wr_full, exp_f);
            end
        end
        wr_en = 1'b1; wr_data = 8'h3C;
        @(posedge wr_clk); #1;
        wr_en = 1'b0;
        vecs++;
        if (wr_overflow !== 1'b1 || wr_full !== 1'b1) begin
            errs++;
            $display("FAIL overflow: got ovf %b full %b want 1 1",
                     wr_overflow, wr_full);
        end
        settle();
        read_burst(16, "drain");
        vecs++;
        if (rd_empty !== 1'b1 || wr_overflow !== 1'b1) begin
            errs++;
            $display("FAIL drain_end: got empty %b ovf %b want 1 1",
                     rd_empty, wr_overflow);
        end
    endtask

    task automatic test_lines();
        apply_reset(4);
        for (int i = 0; i < 10; i++) write_word(W'(i));
        settle();
        vecs++;
        if (rd_line_avail !== avail_model()) begin
            errs++;
            $display("FAIL lines_avail0: got %0d want %0d",
                     rd_line_avail, avail_model());
        end
        read_burst(4, "line1");
        vecs++;
        if (rd_line_avail !== avail_model()) begin
            errs++;
            $display("FAIL lines_avail1: got %0d want %0d",
                     rd_line_avail, avail_model());
        end
        read_burst(4, "line2");
        vecs++;
        if (rd_line_avail !== avail_model()) begin
            errs++;
            $display("FAIL lines_avail2: got %0d want %0d",
                     rd_line_avail, avail_model());
        end
        read_burst(2, "line_tail");
    endtask

    task automatic test_underflow();
        settle();
        @(posedge rd_clk); #1;
        vecs++;
        if (rd_underflow !== 1'b0) begin
            errs++; $display("FAIL udf_pre: got %b want 0", rd_underflow);
        end
        rd_en = 1'b1;
        @(posedge rd_clk); #1;
        rd_en = 1'b0;
        vecs++;
        if (rd_underflow !== 1'b1 || rd_valid !== 1'b0) begin
            errs++;
            $display("FAIL underflow: got udf %b valid %b want 1 0",
                     rd_underflow, rd_valid);
        end
    endtask

    task automatic test_stream();
        rd_half = 7.5;
        settle();
        fork
            begin
                int n;
                int cyc;
                logic [W-1:0] d;
                logic acc;
                n = 0; cyc = 0;
                @(posedge wr_clk); #1;
                while (n < 100 && cyc < 5000) begin
                    d = W'($urandom);
                    wr_data = d;
                    wr_en = ($urandom_range(0, 2) != 0);
                    acc = wr_en && !wr_full;
                    @(posedge wr_clk); #1;
                    cyc++;
                    if (acc) begin
                        mq.push_back(d); n++; wr_total++;
                    end
                end
                wr_en = 1'b0;
            end
            begin
                int got;
                int cyc;
                logic [W-1:0] exp_d;
                logic exp_e;
                got = 0; cyc = 0;
                @(posedge rd_clk); #1;
                while (got < 100 && cyc < 3000) begin
                    rd_en = ($urandom_range(0, 2) != 0);
                    @(posedge rd_clk); #1;
                    cyc++;
                    if (rd_valid === 1'b1) begin
                        got++;
                        vecs++;
                        if (mq.size() == 0) begin
                            errs++;
                            $display("FAIL stream_extra: got valid with %0d queued want none",
                                     mq.size());
                        end else begin
                            exp_d = mq.pop_front();
                            exp_e = (ll == 0) ? 1'b0 :
                                    (((rd_total + 1) % ll) == 0);
                            rd_total++;
                            if (rd_data !== exp_d || rd_eol !== exp_e) begin
                                errs++;
                                $display("FAIL stream[%0d]: got %h eol %b want %h eol %b",
                                         got, rd_data, rd_eol, exp_d, exp_e);
                            end
                        end
                    end
                end
                rd_en = 1'b0;
                vecs++;
                if (got != 100) begin
                    errs++;
                    $display("FAIL stream_count: got %0d words want 100", got);
                end
            end
        join
        settle();
        vecs++;
        if (rd_empty !== 1'b1 || mq.size() != 0 ||
            rd_line_avail !== avail_model()) begin
            errs++;
            $display("FAIL stream_end: got empty %b left %0d avail %0d want 1 0 %0d",
                     rd_empty, mq.size(), rd_line_avail, avail_model());
        end
    endtask

    task automatic test_line_off();
        apply_reset(0);
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 10; i++) write_word(W'($urandom));
            settle();
            read_burst(10, "line_off");
            vecs++;
            if (rd_line_avail !== '0) begin
                errs++;
                $display("FAIL line_off_avail[%0d]: got %0d want 0",
                         k, rd_line_avail);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_fill();
        test_lines();
        test_underflow();
        test_stream();
        test_line_off();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
